// File: rtl/car_light_pkg.sv
// Shared light-state codes for the rear-light block and its command sequencer.
// The codes are one-cold; all-ones means STOP.
package car_light_pkg;

    localparam logic [3:0] CODE_STOP  = 4'b1111;
    localparam logic [3:0] CODE_GO    = 4'b1110;
    localparam logic [3:0] CODE_LEFT  = 4'b1101;
    localparam logic [3:0] CODE_RIGHT = 4'b1011;
    localparam logic [3:0] CODE_BACK  = 4'b0111;

    typedef enum logic [3:0] {
        StStop  = CODE_STOP,
        StGo    = CODE_GO,
        StLeft  = CODE_LEFT,
        StRight = CODE_RIGHT,
        StBack  = CODE_BACK
    } light_state_t;

    // Fixed-priority arbitration; the first matching rule wins.
    function automatic light_state_t select_target(input logic brake, input logic back,
                                                   input logic left, input logic right,
                                                   input logic go);
        if (brake)             return StStop;
        else if (back)         return StBack;
        else if (left && right) return StStop;
        else if (left)         return StLeft;
        else if (right)        return StRight;
        else if (go)           return StGo;
        else                   return StStop;
    endfunction

endpackage

// File: rtl/ctrl_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw switch.
// dout follows the synchronised input once it has differed for DEB_CYCLES cycles in a row.
module ctrl_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned CNT_W      = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dout  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/car_light_ctrl.sv
// Rear-light command sequencer: debounced switches, priority arbitration, turn dwell.
// Define REVERSE_INTERLOCK_EN to force GO<->BACK changes through a timed STOP.
module car_light_ctrl #(
    parameter int unsigned DEB_CYCLES   = 1_000_000,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned CNT_W        = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_brake,
    input  logic       sw_back,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_go,
    output logic [3:0] state_out,
    output logic       state_chg,
    output logic       dwell_busy
);

    import car_light_pkg::*;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    logic [4:0]       raw;
    logic [4:0]       deb;
    light_state_t     state;
    light_state_t     target;
    logic [CNT_W-1:0] dwell_cnt;

    assign raw = {sw_go, sw_right, sw_left, sw_back, sw_brake};

    for (genvar i = 0; i < 5; i++) begin : g_deb
        ctrl_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .din (raw[i]),
            .dout(deb[i])
        );
    end

    always_comb begin
        target = select_target(deb[0], deb[1], deb[2], deb[3], deb[4]);
    end

    assign state_out  = state;
    assign dwell_busy = (dwell_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StStop;
            state_chg <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            state_chg <= 1'b0;
            if (dwell_busy) begin
                // Brake is the only thing allowed to cut a dwell short.
                if (deb[0]) begin
                    state     <= StStop;
                    dwell_cnt <= '0;
                    state_chg <= (state != StStop);
                end else begin
                    dwell_cnt <= dwell_cnt - CNT_W'(1);
                end
            end else if (target != state) begin
                state_chg <= 1'b1;
`ifdef REVERSE_INTERLOCK_EN
                if ((state == StGo && target == StBack) ||
                    (state == StBack && target == StGo)) begin
                    state     <= StStop;
                    dwell_cnt <= DWELL_LOAD;
                end else
`endif
                begin
                    state     <= target;
                    dwell_cnt <= (target == StLeft || target == StRight) ? DWELL_LOAD : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_car_light_ctrl.sv
// Self-checking bench for car_light_ctrl: vector table, directed timing sequences,
// and randomized switches checked every cycle against a behavioural model.
module tb_car_light_ctrl;

    localparam int DEB   = 4;
    localparam int DWELL = 10;

    localparam logic [3:0] STOP  = 4'b1111;
    localparam logic [3:0] GO    = 4'b1110;
    localparam logic [3:0] LEFT  = 4'b1101;
    localparam logic [3:0] RIGHT = 4'b1011;
    localparam logic [3:0] BACK  = 4'b0111;

`ifdef REVERSE_INTERLOCK_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_brake = 1'b0, sw_back = 1'b0, sw_left = 1'b0, sw_right = 1'b0;
    logic       sw_go = 1'b0;
    logic [3:0] state_out;
    logic       state_chg;
    logic       dwell_busy;

    car_light_ctrl #(
        .DEB_CYCLES  (DEB),
        .DWELL_CYCLES(DWELL),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_brake  (sw_brake),
        .sw_back   (sw_back),
        .sw_left   (sw_left),
        .sw_right  (sw_right),
        .sw_go     (sw_go),
        .state_out (state_out),
        .state_chg (state_chg),
        .dwell_busy(dwell_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Switch vector layout: {go, right, left, back, brake}
    task automatic set_sw(input logic [4:0] v);
        {sw_go, sw_right, sw_left, sw_back, sw_brake} = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [4:0] m_s1, m_s2, m_db;
    int         m_run [5];
    logic [3:0] m_state;
    int         m_left;
    logic       m_chg;
    logic [3:0] m_tgt, m_prev;
    bit         chk_en = 1'b0;

    function automatic logic [3:0] want(input logic [4:0] d);
        if (d[0])             return STOP;
        if (d[1])             return BACK;
        if (d[2] && d[3])     return STOP;
        if (d[2])             return LEFT;
        if (d[3])             return RIGHT;
        if (d[4])             return GO;
        return STOP;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_db = '0;
                for (int i = 0; i < 5; i++) m_run[i] = 0;
                m_state = STOP; m_left = 0; m_chg = 1'b0;
            end else begin
                m_tgt  = want(m_db);
                m_prev = m_state;
                if (m_left > 0) begin
                    if (m_db[0]) begin
                        m_state = STOP;
                        m_left  = 0;
                    end else begin
                        m_left = m_left - 1;
                    end
                end else if (m_tgt != m_state) begin
                    if (IL && ((m_state == GO && m_tgt == BACK) ||
                               (m_state == BACK && m_tgt == GO))) begin
                        m_state = STOP;
                        m_left  = DWELL - 1;
                    end else begin
                        m_state = m_tgt;
                        m_left  = (m_tgt == LEFT || m_tgt == RIGHT) ? DWELL - 1 : 0;
                    end
                end
                m_chg = (m_state != m_prev);
                for (int i = 0; i < 5; i++) begin
                    if (m_s2[i] != m_db[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == DEB) begin
                            m_db[i]  = m_s2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_s2 = m_s1;
                m_s1 = {sw_go, sw_right, sw_left, sw_back, sw_brake};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                check("model_state", state_out, m_state);
                check("model_chg", {3'b0, state_chg}, {3'b0, m_chg});
                check("model_busy", {3'b0, dwell_busy}, {3'b0, (m_left > 0)});
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [4:0] sw;
        int         cycles;
        logic [3:0] exp_state;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{5'b00000, 3,  STOP, 1'b0};
        vecs[1] = '{5'b10000, 10, GO,   1'b0};
        vecs[2] = IL ? '{5'b10010, 10, STOP, 1'b1} : '{5'b10010, 10, BACK, 1'b0};
        vecs[3] = '{5'b10010, 10, BACK, 1'b0};
        vecs[4] = '{5'b00000, 10, STOP, 1'b0};
        vecs[5] = '{5'b01100, 10, STOP, 1'b0};
        vecs[6] = '{5'b00100, 10, LEFT, 1'b1};
        vecs[7] = '{5'b00000, 20, STOP, 1'b0};

        set_sw(5'b00000);
        tick(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_state", state_out, STOP);
        check("reset_chg", {3'b0, state_chg}, 4'd0);
        check("reset_busy", {3'b0, dwell_busy}, 4'd0);

        for (int v = 0; v < 8; v++) begin
            set_sw(vecs[v].sw);
            tick(vecs[v].cycles);
            check($sformatf("vec%0d_state", v), state_out, vecs[v].exp_state);
            check($sformatf("vec%0d_busy", v), {3'b0, dwell_busy}, {3'b0, vecs[v].exp_busy});
        end

        // Drive latency: DEB+3 clocks from the raw edge.
        set_sw(5'b10000);
        tick(6);
        check("go_early", state_out, STOP);
        tick(1);
        check("go_edge", state_out, GO);
        check("go_chg", {3'b0, state_chg}, 4'd1);
        tick(1);
        check("go_chg_drop", {3'b0, state_chg}, 4'd0);

        // Short glitch on go is filtered.
        set_sw(5'b00000);
        tick(3);
        set_sw(5'b10000);
        tick(10);
        check("glitch_hold", state_out, GO);
        set_sw(5'b00000);
        tick(10);
        check("go_release", state_out, STOP);

        // Short left pulse still gets a full dwell.
        set_sw(5'b00100);
        tick(5);
        set_sw(5'b00000);
        tick(2);
        check("left_enter", state_out, LEFT);
        check("left_busy", {3'b0, dwell_busy}, 4'd1);
        tick(9);
        check("left_hold", state_out, LEFT);
        tick(1);
        check("left_done", state_out, STOP);

        // Right requested mid-dwell waits for the dwell to expire.
        set_sw(5'b00100);
        tick(5);
        set_sw(5'b00000);
        tick(2);
        check("left2_enter", state_out, LEFT);
        set_sw(5'b01000);
        tick(9);
        check("right_blocked", state_out, LEFT);
        tick(1);
        check("right_enter", state_out, RIGHT);
        check("right_chg", {3'b0, state_chg}, 4'd1);
        set_sw(5'b00000);
        tick(20);
        check("right_release", state_out, STOP);

        // Brake pre-empts a running dwell.
        set_sw(5'b00100);
        tick(8);
        check("left3_enter", state_out, LEFT);
        set_sw(5'b00101);
        tick(6);
        check("brake_early", state_out, LEFT);
        check("brake_early_busy", {3'b0, dwell_busy}, 4'd1);
        tick(1);
        check("brake_stop", state_out, STOP);
        check("brake_busy_clear", {3'b0, dwell_busy}, 4'd0);
        set_sw(5'b00000);
        tick(20);

        // Asynchronous reset in the middle of a dwell.
        set_sw(5'b00100);
        tick(8);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", state_out, STOP);
        check("async_rst_busy", {3'b0, dwell_busy}, 4'd0);
        check("async_rst_chg", {3'b0, state_chg}, 4'd0);
        set_sw(5'b00000);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        check("post_rst_state", state_out, STOP);

        // Randomized switches against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(999) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(15) == 0) sw_brake = ~sw_brake;
            if ($urandom_range(15) == 0) sw_back  = ~sw_back;
            if ($urandom_range(11) == 0) sw_left  = ~sw_left;
            if ($urandom_range(11) == 0) sw_right = ~sw_right;
            if ($urandom_range(9)  == 0) sw_go    = ~sw_go;
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
